// File: rtl/freq_meas.sv
// Period / high-time meter for a slow clock-like input.
// Reports rise-to-rise distance, lock on a stable period, and a sticky timeout.
module freq_meas #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CNT    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         sig_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         valid,
    output logic         locked,
    output logic         timeout
);

    localparam int            LW   = $clog2(LOCK_CNT + 1);
    localparam logic [W-1:0]  CMAX = '1;
    localparam logic [LW-1:0] LMAX = LW'(LOCK_CNT);

    typedef enum logic {
        IDLE,
        MEAS
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   s_d;
    logic                   rise;

    state_t        state;
    state_t        state_n;
    logic [W-1:0]  cnt;
    logic [W-1:0]  cnt_n;
    logic [W-1:0]  hcnt;
    logic [W-1:0]  hcnt_n;
    logic [W-1:0]  period_n;
    logic [W-1:0]  high_n;
    logic          valid_n;
    logic          locked_n;
    logic          timeout_n;
    logic          first;
    logic          first_n;
    logic [LW-1:0] lcnt;
    logic [LW-1:0] lcnt_n;

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync <= '0;
            s_d  <= 1'b0;
        end else begin
            sync[0] <= sig_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
            s_d <= s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            timeout   <= 1'b0;
            first     <= 1'b0;
            lcnt      <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            hcnt      <= hcnt_n;
            period    <= period_n;
            high_time <= high_n;
            valid     <= valid_n;
            locked    <= locked_n;
            timeout   <= timeout_n;
            first     <= first_n;
            lcnt      <= lcnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hcnt_n    = hcnt;
        period_n  = period;
        high_n    = high_time;
        valid_n   = 1'b0;
        locked_n  = locked;
        timeout_n = timeout;
        first_n   = first;
        lcnt_n    = lcnt;
        if (!en) begin
            state_n  = IDLE;
            locked_n = 1'b0;
            lcnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_n = MEAS;
                        cnt_n   = W'(1);
                        hcnt_n  = W'(1);
                        first_n = 1'b1;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        period_n  = cnt;
                        high_n    = hcnt;
                        valid_n   = 1'b1;
                        timeout_n = 1'b0;
                        cnt_n     = W'(1);
                        hcnt_n    = W'(1);
                        first_n   = 1'b0;
                        // period still holds the previous measurement here
                        if (first || cnt != period) begin
                            lcnt_n = '0;
                        end else if (lcnt != LMAX) begin
                            lcnt_n = lcnt + LW'(1);
                        end
                        locked_n = (lcnt_n == LMAX);
                    end else if (cnt == CMAX) begin
                        state_n   = IDLE;
                        timeout_n = 1'b1;
                        locked_n  = 1'b0;
                        lcnt_n    = '0;
                    end else begin
                        cnt_n = cnt + W'(1);
                        if (s) begin
                            hcnt_n = hcnt + W'(1);
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meas.sv
// Randomized bench for freq_meas against an edge-list reference model.
// The model works on the sampled waveform and rise positions, not on the FSM.
module tb_freq_meas;

    localparam int W    = 5;
    localparam int S    = 2;
    localparam int L    = 4;
    localparam int MAXC = (1 << W) - 1;
    localparam int NX   = 16384;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         sig_in = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         locked;
    logic         timeout;

    freq_meas #(.W(W), .SYNC_STAGES(S), .LOCK_CNT(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    bit xs [NX];
    int e        = -1;
    int last_rst = -1;
    int armed    = 0;
    int last_r   = 0;
    int pq[$];
    int m_period, m_high, m_valid, m_locked, m_timeout;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s edge=%0d got=%0d exp=%0d", tag, e, got, exp);
    endtask

    function automatic int xv(input int i);
        if (i < 0 || i <= last_rst) return 0;
        return int'(xs[i]);
    endfunction

    // locked iff the last L+1 periods since arming are all equal
    function automatic int lock_of();
        int n = pq.size();
        if (n < L + 1) return 0;
        for (int i = 1; i <= L; i++)
            if (pq[n-1-i] != pq[n-1]) return 0;
        return 1;
    endfunction

    task automatic model();
        int rs, h;
        e++;
        xs[e] = sig_in;
        m_valid = 0;
        if (!rst) begin
            last_rst  = e;
            armed     = 0;
            pq.delete();
            m_period  = 0;
            m_high    = 0;
            m_locked  = 0;
            m_timeout = 0;
            return;
        end
        rs = xv(e - S) & ~xv(e - S - 1) & 1;
        if (!en) begin
            armed    = 0;
            m_locked = 0;
        end else if (!armed) begin
            if (rs != 0) begin
                armed  = 1;
                last_r = e;
                pq.delete();
            end
        end else if (rs != 0) begin
            h = 0;
            for (int j = last_r; j < e; j++) h += xv(j - S);
            m_period  = e - last_r;
            m_high    = h;
            m_valid   = 1;
            m_timeout = 0;
            pq.push_back(e - last_r);
            m_locked  = lock_of();
            last_r    = e;
        end else if (e - last_r == MAXC) begin
            m_timeout = 1;
            m_locked  = 0;
            armed     = 0;
        end
    endtask

    task automatic step(input bit r, input bit en_v, input bit v);
        @(negedge clk);
        rst    = r;
        en     = en_v;
        sig_in = v;
        @(posedge clk);
        model();
        #1;
        chk("valid", valid, m_valid);
        chk("period", period, m_period);
        chk("high_time", high_time, m_high);
        chk("locked", locked, m_locked);
        chk("timeout", timeout, m_timeout);
    endtask

    // periodic wave; en or rst dropped for a window when start >= 0
    task automatic wave(input int hi, input int per, input int len,
                        input int en_at, input int en_len, input int rst_at);
        for (int t = 0; t < len; t++) begin
            step(!(rst_at >= 0 && t == rst_at),
                 !(en_at >= 0 && t >= en_at && t < en_at + en_len),
                 (t % per) < hi);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        wave(1, 3, 30, -1, 0, -1);
        wave(2, 7, 50, -1, 0, -1);
        wave(2, 5, 40, -1, 0, -1);
        wave(4, 10, 70, -1, 0, -1);
        wave(3, 7, 60, -1, 0, -1);
        wave(10, MAXC, 4 * MAXC, -1, 0, -1);
        wave(4, MAXC + 1, 3 * (MAXC + 1), -1, 0, -1);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0);
        wave(2, 6, 30, -1, 0, -1);
        wave(2, 5, 40, 17, 3, -1);
        wave(3, 8, 40, -1, 0, 13);
        for (int seg = 0; seg < 40; seg++) begin
            int kind = int'($urandom_range(0, 9));
            int per  = int'($urandom_range(2, 18));
            int hi   = int'($urandom_range(1, per - 1));
            int len  = per * int'($urandom_range(3, 8));
            if (kind <= 5) begin
                wave(hi, per, len, -1, 0, -1);
            end else if (kind == 6) begin
                int n = int'($urandom_range(20, 45));
                for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0);
            end else if (kind == 7) begin
                for (int i = 0; i < 25; i++)
                    step(1'b1, 1'b1, 1'($urandom_range(0, 1)));
            end else if (kind == 8) begin
                wave(hi, per, len, int'($urandom_range(0, len - 4)), 3, -1);
            end else begin
                wave(hi, per, len, -1, 0, int'($urandom_range(0, len - 1)));
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
